// File: rtl/irq_arbiter.sv
// Round-robin edge-triggered interrupt arbiter with claim / trap_ack / complete tracking.
// Optional build macro IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_src bit.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               trap_ack,
  input  logic               complete,
  output logic               interrupt,
  output logic [ID_W-1:0]    claim_id,
  output logic               claim_valid
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] enable, enable_nxt;
  logic [NUM_SRC-1:0] pending, pending_nxt;
  logic [NUM_SRC-1:0] prev, src_in, rise;
  logic [NUM_SRC-1:0] cand_rot, cfg_clear, claim_mask;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt, claim_id_nxt, sel_id;
  logic [ID_W:0]      sel_sum;
  logic               interrupt_nxt, claim_valid_nxt, found;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_in = sync2;
`else
  assign src_in = irq_src;
`endif

  if (NUM_SRC < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^cfg_wdata[31:NUM_SRC];
  end

  assign rise       = src_in & ~prev;
  assign claim_mask = NUM_SRC'(1) << claim_id;
  // Rotating the candidates by rr_ptr turns the wrap-around search into a plain lowest-bit search.
  assign cand_rot   = NUM_SRC'({pending & enable, pending & enable} >> rr_ptr);

  always_comb begin
    found   = 1'b0;
    sel_id  = '0;
    sel_sum = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && cand_rot[k]) begin
        found   = 1'b1;
        sel_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (sel_sum >= (ID_W+1)'(NUM_SRC))
          sel_sum = sel_sum - (ID_W+1)'(NUM_SRC);
        sel_id  = sel_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    enable_nxt      = enable;
    cfg_clear       = '0;
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    claim_id_nxt    = claim_id;
    interrupt_nxt   = interrupt;
    claim_valid_nxt = claim_valid;
    if (cfg_we && cfg_addr == ADDR_ENABLE)
      enable_nxt = cfg_wdata[NUM_SRC-1:0];
    if (cfg_we && cfg_addr == ADDR_PENDING)
      cfg_clear = cfg_wdata[NUM_SRC-1:0];
    // A fresh edge always wins over any clear in the same cycle.
    pending_nxt = (pending & ~cfg_clear) | rise;
    case (state)
      IDLE: begin
        if (found) begin
          claim_id_nxt    = sel_id;
          claim_valid_nxt = 1'b1;
          interrupt_nxt   = 1'b1;
          state_nxt       = ASSERT;
        end
      end
      ASSERT: begin
        if (trap_ack) begin
          pending_nxt   = (pending & ~cfg_clear & ~claim_mask) | rise;
          interrupt_nxt = 1'b0;
          rr_ptr_nxt    = (claim_id == ID_W'(NUM_SRC-1)) ? '0 : claim_id + 1'b1;
          state_nxt     = SERVICE;
        end else if ((enable_nxt & pending_nxt & claim_mask) == '0) begin
          interrupt_nxt   = 1'b0;
          claim_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      SERVICE: begin
        if (complete) begin
          claim_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      enable      <= '0;
      pending     <= '0;
      prev        <= '0;
      rr_ptr      <= '0;
      claim_id    <= '0;
      claim_valid <= 1'b0;
      interrupt   <= 1'b0;
    end else begin
      state       <= state_nxt;
      enable      <= enable_nxt;
      pending     <= pending_nxt;
      prev        <= src_in;
      rr_ptr      <= rr_ptr_nxt;
      claim_id    <= claim_id_nxt;
      claim_valid <= claim_valid_nxt;
      interrupt   <= interrupt_nxt;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = 32'(enable);
      ADDR_PENDING: cfg_rdata = 32'(pending);
      ADDR_CLAIM:   cfg_rdata = {claim_valid, {(31-ID_W){1'b0}}, claim_id};
      default:      cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed vector tables plus randomized run against a reference model.
module tb_irq_arbiter;

  localparam int N = 8;

  logic          clk, rst;
  logic [N-1:0]  irq_src;
  logic          cfg_we, trap_ack, complete;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_wdata, cfg_rdata;
  logic          interrupt, claim_valid;
  logic [2:0]    claim_id;

  int tests    = 0;
  int failures = 0;

  irq_arbiter #(.NUM_SRC(N), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .trap_ack(trap_ack), .complete(complete),
    .interrupt(interrupt), .claim_id(claim_id), .claim_valid(claim_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        cmp;
    logic        e_int;
    logic        e_valid;
    logic [2:0]  e_id;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];
  int   split;

  function automatic vec_t mk(input int irq, input int we, input int addr, input logic [31:0] wdata,
                              input int ack, input int cmp, input int e_int, input int e_valid,
                              input int e_id, input logic [31:0] e_rdata);
    vec_t v;
    v.irq = 8'(irq); v.we = 1'(we); v.addr = 2'(addr); v.wdata = wdata;
    v.ack = 1'(ack); v.cmp = 1'(cmp);
    v.e_int = 1'(e_int); v.e_valid = 1'(e_valid); v.e_id = 3'(e_id); v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference model: source bits, enables and pendings as plain bit arrays, pointer arithmetic mod N.
  bit          m_en[N], m_pend[N], m_last[N];
  logic [N-1:0] m_hist[$];
  int          m_phase, m_ptr, m_claim;
  bit          m_int, m_valid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_last[i] = 0;
    end
    m_hist = {};
`ifdef IRQ_SYNC_EN
    m_hist.push_back('0);
    m_hist.push_back('0);
`endif
    m_phase = 0; m_ptr = 0; m_claim = 0; m_int = 0; m_valid = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] seen;
    bit req[N], en_n[N], pend_n[N];
    int best;
`ifdef IRQ_SYNC_EN
    m_hist.push_back(irq_src);
    seen = m_hist.pop_front();
`else
    seen = irq_src;
`endif
    for (int i = 0; i < N; i++) begin
      req[i]    = seen[i] && !m_last[i];
      m_last[i] = seen[i];
      en_n[i]   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[i] : m_en[i];
      pend_n[i] = (m_pend[i] && !(cfg_we && cfg_addr == 2'd1 && cfg_wdata[i])) || req[i];
    end
    if (m_phase == 0) begin
      best = -1;
      for (int k = 0; k < N; k++)
        if (best < 0 && m_pend[(m_ptr + k) % N] && m_en[(m_ptr + k) % N]) best = (m_ptr + k) % N;
      if (best >= 0) begin
        m_claim = best; m_valid = 1; m_int = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (trap_ack) begin
        if (!req[m_claim]) pend_n[m_claim] = 0;
        m_int = 0; m_ptr = (m_claim + 1) % N; m_phase = 2;
      end else if (!en_n[m_claim] || !pend_n[m_claim]) begin
        m_int = 0; m_valid = 0; m_phase = 0;
      end
    end else begin
      if (complete) begin
        m_valid = 0; m_phase = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_en[i]   = en_n[i];
      m_pend[i] = pend_n[i];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (addr == 2'd0) r[i] = m_en[i];
      if (addr == 2'd1) r[i] = m_pend[i];
    end
    if (addr == 2'd2) r = {m_valid, 28'b0, 3'(m_claim)};
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    irq_src = v.irq; cfg_we = v.we; cfg_addr = v.addr; cfg_wdata = v.wdata;
    trap_ack = v.ack; complete = v.cmp;
    @(posedge clk); #2;
    check_output($sformatf("row%0d interrupt", idx), 32'(interrupt), 32'(v.e_int));
    check_output($sformatf("row%0d claim_valid", idx), 32'(claim_valid), 32'(v.e_valid));
    if (v.e_valid) check_output($sformatf("row%0d claim_id", idx), 32'(claim_id), 32'(v.e_id));
    check_output($sformatf("row%0d cfg_rdata", idx), cfg_rdata, v.e_rdata);
  endtask

  task automatic drive_idle();
    irq_src = '0; cfg_we = 0; cfg_addr = 2'd0; cfg_wdata = '0; trap_ack = 0; complete = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " interrupt"}, 32'(interrupt), 32'd0);
    check_output({tag, " claim_valid"}, 32'(claim_valid), 32'd0);
    check_output({tag, " claim_id"}, 32'(claim_id), 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      check_output($sformatf("%s rdata[%0d]", tag, a), cfg_rdata, 32'd0);
    end
  endtask

  initial begin
`ifndef IRQ_SYNC_EN
    // irq, we, addr, wdata, ack, cmp | int, valid, id, rdata
    tbl.push_back(mk('h00,1,0,32'h01,0,0, 0,0,0,32'h01));
    tbl.push_back(mk('h01,0,1,32'h00,0,0, 0,0,0,32'h01));
    tbl.push_back(mk('h00,0,1,32'h00,0,0, 1,1,0,32'h01));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,0,32'h00));
    tbl.push_back(mk('h00,0,2,32'h00,0,0, 0,1,0,32'h8000_0000));
    tbl.push_back(mk('h00,0,2,32'h00,0,1, 0,0,0,32'h00));
    tbl.push_back(mk('h00,1,0,32'hFF,0,0, 0,0,0,32'hFF));
    tbl.push_back(mk('h24,0,1,32'h00,0,0, 0,0,0,32'h24));
    tbl.push_back(mk('h24,0,2,32'h00,0,0, 1,1,2,32'h8000_0002));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,2,32'h20));
    tbl.push_back(mk('h00,0,1,32'h00,0,1, 0,0,0,32'h20));
    tbl.push_back(mk('h00,0,2,32'h00,0,0, 1,1,5,32'h8000_0005));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,5,32'h00));
    tbl.push_back(mk('h24,0,1,32'h00,0,1, 0,0,0,32'h24));
    tbl.push_back(mk('h24,0,2,32'h00,0,0, 1,1,2,32'h8000_0002));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,2,32'h20));
    tbl.push_back(mk('h00,1,1,32'h20,0,1, 0,0,0,32'h00));
    tbl.push_back(mk('h00,1,0,32'h00,0,0, 0,0,0,32'h00));
    tbl.push_back(mk('h08,0,1,32'h00,0,0, 0,0,0,32'h08));
    tbl.push_back(mk('h00,0,1,32'h00,0,0, 0,0,0,32'h08));
    tbl.push_back(mk('h00,1,0,32'h08,0,0, 0,0,0,32'h08));
    tbl.push_back(mk('h00,0,2,32'h00,0,0, 1,1,3,32'h8000_0003));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,3,32'h00));
    tbl.push_back(mk('h00,0,1,32'h00,0,1, 0,0,0,32'h00));
    tbl.push_back(mk('h00,1,0,32'h02,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h02,0,1,32'h00,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h02,0,2,32'h00,0,0, 1,1,1,32'h8000_0001));
    tbl.push_back(mk('h00,1,0,32'h00,0,0, 0,0,0,32'h00));
    tbl.push_back(mk('h00,0,1,32'h00,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h00,1,0,32'h02,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h00,0,2,32'h00,0,0, 1,1,1,32'h8000_0001));
    tbl.push_back(mk('h00,1,0,32'h00,1,0, 0,1,1,32'h00));
    tbl.push_back(mk('h00,0,1,32'h00,0,0, 0,1,1,32'h00));
    tbl.push_back(mk('h00,0,2,32'h00,0,1, 0,0,0,32'h01));
    tbl.push_back(mk('h00,1,0,32'h50,0,0, 0,0,0,32'h50));
    tbl.push_back(mk('h10,0,1,32'h00,0,0, 0,0,0,32'h10));
    tbl.push_back(mk('h00,0,2,32'h00,0,0, 1,1,4,32'h8000_0004));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,4,32'h00));
    tbl.push_back(mk('h40,0,1,32'h00,0,0, 0,1,4,32'h40));
    tbl.push_back(mk('h00,0,1,32'h00,0,0, 0,1,4,32'h40));
    tbl.push_back(mk('h00,0,2,32'h00,0,1, 0,0,0,32'h04));
    tbl.push_back(mk('h00,0,2,32'h00,0,0, 1,1,6,32'h8000_0006));
    split = tbl.size();
    tbl.push_back(mk('h02,0,1,32'h00,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h00,0,1,32'h00,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h02,1,1,32'h02,0,0, 0,0,0,32'h02));
    tbl.push_back(mk('h00,1,1,32'h02,0,0, 0,0,0,32'h00));
`else
    // Synchronized build: an edge in row N shows as pending after row N+2, interrupt after row N+3.
    tbl.push_back(mk('h00,1,0,32'h01,0,0, 0,0,0,32'h01));
    tbl.push_back(mk('h01,0,1,32'h00,0,0, 0,0,0,32'h00));
    tbl.push_back(mk('h01,0,1,32'h00,0,0, 0,0,0,32'h00));
    tbl.push_back(mk('h01,0,1,32'h00,0,0, 0,0,0,32'h01));
    tbl.push_back(mk('h01,0,2,32'h00,0,0, 1,1,0,32'h8000_0000));
    tbl.push_back(mk('h00,0,1,32'h00,1,0, 0,1,0,32'h00));
    tbl.push_back(mk('h00,0,2,32'h00,0,1, 0,0,0,32'h00));
    split = tbl.size();
`endif
    tbl.push_back(mk('h00,1,0,32'hFFFF_FF01,0,0, 0,0,0,32'h01));
    tbl.push_back(mk('h00,1,3,32'hDEAD_BEEF,0,0, 0,0,0,32'h00));
    tbl.push_back(mk('h00,1,2,32'hFFFF_FFFF,0,0, 0,0,0,32'h00));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_state("reset");
    rst = 1'b0;
    cfg_addr = 2'd0;

    for (int i = 0; i < split; i++) apply_stimulus(tbl[i], i);

    // Reset in the middle of an active claim clears everything at once.
    #1;
    rst = 1'b1;
    #1;
    check_output("midreset interrupt", 32'(interrupt), 32'd0);
    check_output("midreset claim_valid", 32'(claim_valid), 32'd0);
    check_output("midreset claim_id", 32'(claim_id), 32'd0);
    drive_idle();
    @(posedge clk); #2;
    check_reset_state("midreset");
    rst = 1'b0;

    for (int i = split; i < tbl.size(); i++) apply_stimulus(tbl[i], i);

    drive_idle();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      irq_src   = irq_src ^ N'($urandom & $urandom & $urandom);
      cfg_we    = ($urandom_range(0, 99) < 15);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = ($urandom_range(0, 1) == 1) ? $urandom : {24'h0, 8'($urandom)};
      trap_ack  = (m_phase == 1) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
      complete  = (m_phase == 2) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
      if (trap_ack && complete && m_phase != 2) complete = 1'b0;
      @(posedge clk); #2;
      check_output($sformatf("rand%0d interrupt", c), 32'(interrupt), 32'(m_int));
      check_output($sformatf("rand%0d claim_valid", c), 32'(claim_valid), 32'(m_valid));
      if (m_valid) check_output($sformatf("rand%0d claim_id", c), 32'(claim_id), 32'(m_claim));
      check_output($sformatf("rand%0d cfg_rdata", c), cfg_rdata, model_read(cfg_addr));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Round-robin interrupt arbiter/controller in front of the exception unit.
- Collects NUM_SRC external edge-triggered interrupt requests and latches them as pending bits.
- Selects one enabled pending source, drives the single `interrupt` line, and tracks the claimed source through the take-trap / mret complete handshake.
- Exposes enable, pending and claim state through a small CSR-style config port.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- ID_W, 3, width of source id; must satisfy 2^ID_W >= NUM_SRC.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SRC  raw level request per source; a 0->1 edge is a request
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0=ENABLE, 1=PENDING, 2=CLAIM, 3=reserved
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  combinational read data for cfg_addr
- trap_ack  in  1  exception unit took the interrupt trap this cycle
- complete  in  1  handler done (mret) this cycle
- interrupt  out  1  registered request to the exception unit
- claim_id  out  ID_W  id of selected/in-service source
- claim_valid  out  1  claim_id is meaningful

Behaviour:
- Reset (async): enable=0, pending=0, rr_ptr=0, state=IDLE, interrupt=0, claim_id=0, claim_valid=0, edge-detect history=0.
- Edge detect: prev<=irq_src every cycle. Rising edge of source i in cycle N sets pending[i] at N+1. A level held high does not re-trigger.
- PENDING write: cfg_wdata bit i = 1 clears pending[i]. A same-cycle new edge on i wins (bit stays/becomes 1).
- ENABLE: read/write of bits [NUM_SRC-1:0]. Upper bits read 0 and ignore writes.
- Disabled sources still latch pending but are never selected.
- CLAIM read: {claim_valid, zeros, claim_id}, with claim_valid at bit 31. Writes are ignored.
- States:
  - IDLE: candidates = pending & enable. If nonzero, pick the first set bit searching upward from rr_ptr with wrap-around. Latch claim_id, set claim_valid=1 and interrupt=1, go to ASSERT. With a pending bit set at N+1, interrupt is high at N+2.
  - ASSERT: claim_id is held stable.
    - trap_ack=1: clear pending[claim_id], interrupt<=0, rr_ptr<=(claim_id+1) mod NUM_SRC, go to SERVICE.
    - Else, if enable[claim_id]=0 or pending[claim_id] is cleared by config: withdraw. interrupt<=0, claim_valid<=0, go to IDLE next cycle.
    - trap_ack has priority over withdrawal in the same cycle.
  - SERVICE: interrupt=0, claim_valid=1, new requests only accumulate as pending (no nesting). On complete=1, claim_valid<=0 and go to IDLE. A new selection may start the following cycle.
- Ignored inputs: trap_ack outside ASSERT; complete outside SERVICE.
- trap_ack and complete both high is legal only in SERVICE, where only complete acts.
- rr_ptr wraps from NUM_SRC-1 to 0.
- Reset asserted mid-ASSERT or mid-SERVICE returns to the reset state immediately. Pending requests are lost.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: each irq_src bit passes through a 2-flop synchronizer before edge detect. All source-to-pending latencies grow by 2 cycles, so an edge at N gives pending at N+3 and interrupt at N+4. Synchronizer flops reset to 0.
- Undefined: irq_src feeds edge detect directly.

Test Plan:
- Reset then ENABLE=0x01; pulse irq_src[0] at cycle 10 -> pending[0]=1 at cycle 11, interrupt=1 and claim_id=0 at cycle 12; trap_ack -> interrupt=0, pending[0]=0, next cycle state SERVICE.
- ENABLE=0xFF, rr_ptr=0; raise irq_src[2] and [5] together -> claim 2 first; after ack/complete, claim 5; then re-raise both -> claim 2 again (rr_ptr=6 wraps).
- ENABLE=0x00; pulse irq_src[3] -> pending=0x08, interrupt stays 0; write ENABLE=0x08 -> interrupt=1 two cycles later, claim_id=3.
- In ASSERT for source 1, write ENABLE=0 with no trap_ack -> interrupt=0 and claim_valid=0 next cycle; repeat with trap_ack in the same cycle -> ack wins and state becomes SERVICE.
- In SERVICE for source 4, pulse irq_src[6] -> interrupt stays 0 and pending[6]=1; complete -> IDLE, then interrupt=1 with claim_id=6; assert rst mid-ASSERT -> all outputs 0 immediately.
- PENDING write 0x02 in the same cycle as an irq_src[1] rising edge -> pending[1]=1; IRQ_SYNC_EN build: edge at N -> interrupt at N+4.
